// File: rtl/mul_share_arbiter_if.sv
// Bus bundle for mul_share_arbiter: requester channels, response channel and multiplier port.
// slave = arbiter side, master = requesters/consumer/multiplier side.
interface mul_share_arbiter_if #(
  parameter int NB  = 8,
  parameter int R   = 4,
  parameter int IDW = 2
);
  logic [R-1:0]     req_valid;
  logic [R*NB-1:0]  req_a;
  logic [R*NB-1:0]  req_b;
  logic [R-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [2*NB-1:0]  rsp_product;
  logic             rsp_err;
  logic             mul_start;
  logic [NB-1:0]    mul_a;
  logic [NB-1:0]    mul_b;
  logic [2*NB-1:0]  mul_product;
  logic             mul_ready;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_product, mul_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_product, mul_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential signed multiplier between R requesters.
// Optional WAIT timeout with error response is built when MUL_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | grant next valid requester round-robin, latch its operands and ID
// ISSUE | one-cycle mul_start pulse
// WAIT  | wait for mul_ready, ignoring it in the first cycle
// RESP  | hold response until rsp_ready, then advance pointer
module mul_share_arbiter #(
  parameter int NB      = 8,
  parameter int R       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = NB + 4
) (
  input logic                clk,
  input logic                rst_n,
  mul_share_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]   a_q, a_d;
  logic [NB-1:0]   b_q, b_d;
  logic [2*NB-1:0] prod_q, prod_d;
`ifdef MUL_ARB_TIMEOUT_EN
  logic            err_q, err_d;
`endif

  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cand;
  logic [NB-1:0]   gnt_a, gnt_b;

  // Search pointer, pointer+1, ... wrapping at R-1 so non-power-of-two R works.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = ptr_q;
    for (int i = 0; i < R; i++) begin
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
      cand = (cand == IDW'(R - 1)) ? '0 : cand + 1'b1;
    end
    gnt_a = '0;
    gnt_b = '0;
    for (int j = 0; j < R; j++) begin
      if (gnt_id == IDW'(j)) begin
        gnt_a = bus.req_a[j*NB +: NB];
        gnt_b = bus.req_b[j*NB +: NB];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
`ifdef MUL_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d     = gnt_a;
          b_d     = gnt_b;
          id_d    = gnt_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // counter==0 masks a ready level left over from the previous operation
        if (cnt_q != '0 && bus.mul_ready) begin
          prod_d  = bus.mul_product;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
`ifdef MUL_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ptr_d   = (id_q == IDW'(R - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
`ifdef MUL_ARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // rst_n gate keeps the combinational grant low while reset is held.
  assign bus.req_ready   = (state_q == IDLE && gnt_found && rst_n) ? (R'(1) << gnt_id) : '0;
  assign bus.mul_start   = (state_q == ISSUE);
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign bus.rsp_err     = err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed and randomized traffic against a
// round-robin reference model and a sequential multiplier model with a stale ready level.
module tb_mul_share_arbiter;
  localparam int NB      = 8;
  localparam int R       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = NB + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.NB(NB), .R(R), .IDW(IDW)) bus ();

  mul_share_arbiter #(.NB(NB), .R(R), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [R-1:0]    vld;
  logic [NB-1:0]   opa [R];
  logic [NB-1:0]   opb [R];
  int              model_ptr;
  int              tests;
  int              fails;
  bit              never_ready = 1'b0;

  always_comb begin
    bus.req_valid = vld;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < R; i++) begin
      bus.req_a[i*NB +: NB] = opa[i];
      bus.req_b[i*NB +: NB] = opb[i];
    end
  end

  // Sequential multiplier model: ready stays at its old level for one cycle after start.
  logic            m_ready = 1'b0;
  logic [2*NB-1:0] m_prod  = '0;
  logic [NB-1:0]   m_a     = '0;
  logic [NB-1:0]   m_b     = '0;
  int              m_cnt   = 0;
  assign bus.mul_ready   = m_ready;
  assign bus.mul_product = m_prod;

  function automatic logic [2*NB-1:0] smul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return (2*NB)'(ia * ib);
  endfunction

  always @(posedge clk) begin
    if (bus.mul_start) begin
      m_a   <= bus.mul_a;
      m_b   <= bus.mul_b;
      m_cnt <= never_ready ? 1000000 : int'($urandom_range(2, 6));
    end else if (m_cnt > 1) begin
      m_ready <= 1'b0;
      m_cnt   <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_ready <= 1'b1;
      m_prod  <= smul(m_a, m_b);
      m_cnt   <= 0;
    end
  end

  function automatic int model_grant(input logic [R-1:0] v, input int p);
    for (int i = 0; i < R; i++) begin
      if (((v >> ((p + i) % R)) & R'(1)) != '0) return (p + i) % R;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  // Entered and left at a negedge with the arbiter in IDLE.
  task automatic serve(input int hold, input bit rereq, output int gid, output logic [2*NB-1:0] gprod);
    int              g, k, first_q;
    logic [IDW-1:0]  gi;
    logic [NB-1:0]   ea, eb;
    logic [2*NB-1:0] ep;
    bit              bad;
    #1;
    gid   = -1;
    gprod = '0;
    g = model_grant(vld, model_ptr);
    if (g < 0) return;
    gi = IDW'(g);
    ea = opa[gi];
    eb = opb[gi];
    ep = smul(ea, eb);
    check("req_ready", 32'(bus.req_ready), 32'(1 << g));
    check("idle_no_start", 32'(bus.mul_start), 0);
    @(negedge clk);
    if (rereq) begin
      opa[gi] = NB'($urandom);
      opb[gi] = NB'($urandom);
    end else begin
      vld &= ~(R'(1) << g);
    end
    check("mul_start", 32'(bus.mul_start), 1);
    check("mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'({ea, eb}));
    check("issue_no_ready", 32'(bus.req_ready), 0);
    k = 0;
    first_q = -1;
    bad = 1'b0;
    while (!bus.rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
      if (!bus.rsp_valid) begin
        if (bus.mul_start || bus.req_ready != '0 || bus.mul_a !== ea || bus.mul_b !== eb) bad = 1'b1;
        if (first_q < 0 && k >= 2 && bus.mul_ready) first_q = k;
      end
    end
    check("wait_quiet", 32'(bad), 0);
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("latency", 32'(k), 32'(first_q + 1));
    check("rsp_id", 32'(bus.rsp_id), 32'(g));
    check("rsp_product", 32'(bus.rsp_product), 32'(ep));
    check("rsp_err", 32'(bus.rsp_err), 0);
    gid   = int'(bus.rsp_id);
    gprod = bus.rsp_product;
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id !== gi || bus.rsp_product !== ep || bus.rsp_err !== 1'b0 ||
          bus.req_ready != '0 || bus.mul_start) bad = 1'b1;
    end
    if (hold > 0) check("hold_stable", 32'(bad), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.rsp_valid), 0);
    model_ptr = (g + 1) % R;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int              gid, k, g;
    logic [2*NB-1:0] gprod;
    logic [R-1:0]    add;
    bit              bad;
    logic [NB-1:0]   xa [3];
    logic [NB-1:0]   xb [3];
    logic [2*NB-1:0] xp [3];

    tests = 0;
    fails = 0;
    model_ptr = 0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < R; i++) begin
      opa[i] = NB'($urandom);
      opb[i] = NB'($urandom);
    end

    // reset with every requester asserting valid
    vld   = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_mul_start", 32'(bus.mul_start), 0);
    check("rst_mul_ab", 32'({bus.mul_a, bus.mul_b}), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_product", 32'(bus.rsp_product), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    vld   = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // requester 0: -3 * 7
    vld    = 4'b0001;
    opa[0] = 8'hFD;
    opb[0] = 8'h07;
    serve(0, 1'b0, gid, gprod);
    check("dir_id", 32'(gid), 0);
    check("dir_product", 32'(gprod), 32'h0000_FFEB);

    // all four from reset, then only 1 and 3
    do_reset();
    vld = 4'b1111;
    for (int n = 0; n < R; n++) begin
      serve(0, 1'b0, gid, gprod);
      check("order_all", 32'(gid), 32'(n));
    end
    vld = 4'b1010;
    serve(0, 1'b0, gid, gprod);
    check("order_13_first", 32'(gid), 1);
    serve(0, 1'b0, gid, gprod);
    check("order_13_second", 32'(gid), 3);

    // response held for 5 cycles with other requests pending
    vld = 4'b0111;
    serve(5, 1'b1, gid, gprod);
    serve(2, 1'b0, gid, gprod);
    vld = '0;

    // operand extremes
    xa[0] = 8'h80; xb[0] = 8'h80; xp[0] = 16'h4000;
    xa[1] = 8'h80; xb[1] = 8'h7F; xp[1] = 16'hC080;
    xa[2] = 8'h00; xb[2] = 8'hFF; xp[2] = 16'h0000;
    for (int x = 0; x < 3; x++) begin
      g = int'($urandom_range(0, R - 1));
      opa[IDW'(g)] = xa[x];
      opb[IDW'(g)] = xb[x];
      vld = R'(1) << g;
      serve(0, 1'b0, gid, gprod);
      check("extreme_product", 32'(gprod), 32'(xp[x]));
    end

    // randomized traffic; granted requesters may re-request with new operands
    for (int n = 0; n < 30; n++) begin
      add = R'($urandom) & ~vld;
      if (vld == '0 && add == '0) add = R'(1) << $urandom_range(0, R - 1);
      for (int i = 0; i < R; i++) begin
        if (add[i]) begin
          opa[i] = NB'($urandom);
          opb[i] = NB'($urandom);
        end
      end
      vld |= add;
      serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), gid, gprod);
    end
    vld = '0;
    @(negedge clk);
    if (bus.rsp_valid) begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end

    // reset asserted while in WAIT
    never_ready = 1'b1;
    opa[1] = NB'($urandom_range(1, 255));
    opb[1] = NB'($urandom);
    vld    = 4'b0010;
    k = 0;
    while (!bus.mul_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_wait_issue", 32'(bus.mul_start), 1);
    vld = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_ready", 32'(bus.req_ready), 0);
    check("async_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 0);
    check("async_product", 32'(bus.rsp_product), 0);
    check("async_mul", 32'({bus.mul_start, bus.mul_a, bus.mul_b}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    never_ready = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    check("post_rst_no_rsp", 32'(bus.rsp_valid), 0);
    opa[2] = NB'($urandom);
    opb[2] = NB'($urandom);
    vld = 4'b0100;
    serve(0, 1'b0, gid, gprod);
    check("post_rst_id", 32'(gid), 2);

    // multiplier that never raises ready
    never_ready = 1'b1;
    opa[0] = 8'h11; opb[0] = 8'h22;
    opa[2] = 8'h33; opb[2] = 8'h44;
    vld = 4'b0101;
    g = model_grant(vld, model_ptr);
    k = 0;
    while (!bus.mul_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("nr_issue", 32'(bus.mul_start), 1);
    vld &= ~(R'(1) << g);
    k = 0;
`ifdef MUL_ARB_TIMEOUT_EN
    while (!bus.rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("to_wait_cycles", 32'(k), 32'(TIMEOUT + 1));
    check("to_err", 32'(bus.rsp_err), 1);
    check("to_product", 32'(bus.rsp_product), 0);
    check("to_id", 32'(bus.rsp_id), 32'(g));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("to_drop", 32'(bus.rsp_valid), 0);
    model_ptr = (g + 1) % R;
    never_ready = 1'b0;
    serve(0, 1'b0, gid, gprod);
    check("to_next_id", 32'(gid), 2);
`else
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.req_ready != '0 || bus.mul_start) bad = 1'b1;
    end
    check("stuck_in_wait", 32'(bad), 0);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
